// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, round-constant lookup, key-schedule FSM states
// and block-level constants.
package aes_pkg;

  localparam int unsigned AES_N = 128;
  localparam int unsigned AES_R = 10;
  localparam int unsigned IDX_W = $clog2(AES_R + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(AES_R);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GEN  = 1'b1
  } ks_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for the key that becomes round idx; idx 0 has none.
  function automatic logic [7:0] aes_rcon(input logic [IDX_W-1:0] idx);
    logic [7:0] rc;
    rc = 8'h00;
    case (int'(idx))
      1:       rc = 8'h01;
      2:       rc = 8'h02;
      3:       rc = 8'h04;
      4:       rc = 8'h08;
      5:       rc = 8'h10;
      6:       rc = 8'h20;
      7:       rc = 8'h40;
      8:       rc = 8'h80;
      9:       rc = 8'h1b;
      10:      rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/key_expansion_128_if.sv
// Request/round-key bus of the AES-128 key schedule. master = key generator,
// slave = requester/consumer (round datapath).
interface key_expansion_128_if;
  import aes_pkg::*;

  logic             start;
  logic [AES_N-1:0] cipher_key;
  logic             rk_valid;
  logic             rk_ready;
  logic [AES_N-1:0] round_key;
  logic [IDX_W-1:0] rk_idx;
  logic             busy;
  logic             done;

  modport master (
    input  start, cipher_key, rk_ready,
    output rk_valid, round_key, rk_idx, busy, done
  );

  modport slave (
    output start, cipher_key, rk_ready,
    input  rk_valid, round_key, rk_idx, busy, done
  );

endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      word_o[8*i +: 8] = aes_sbox(word_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/key_expansion_128.sv
// AES-128 key schedule: streams round keys 0..10 over a valid/ready handshake,
// deriving each key from the previous one held in round_key_q.
module key_expansion_128
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  key_expansion_128_if.master  bus
);

  ks_state_e        state_q, state_d;
  logic [AES_N-1:0] round_key_q, round_key_d;
  logic [IDX_W-1:0] rk_idx_q, rk_idx_d;
  logic             rk_valid_q, rk_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      sub_rot_w3, t;
  logic [31:0]      w0_n, w1_n, w2_n, w3_n;
  logic [AES_N-1:0] next_key;
  logic [IDX_W-1:0] rk_idx_inc;
  logic             xfer;

  assign {w0, w1, w2, w3} = round_key_q;
  assign rk_idx_inc       = rk_idx_q + IDX_W'(1);
  assign xfer             = rk_valid_q && bus.rk_ready;

  // RotWord is a byte rotate left, folded into the S-box input wiring.
  aes_sub_word u_sub_word (
    .word_i ({w3[23:0], w3[31:24]}),
    .word_o (sub_rot_w3)
  );

  always_comb begin
    t        = sub_rot_w3 ^ {aes_rcon(rk_idx_inc), 24'h000000};
    w0_n     = w0 ^ t;
    w1_n     = w1 ^ w0_n;
    w2_n     = w2 ^ w1_n;
    w3_n     = w3 ^ w2_n;
    next_key = {w0_n, w1_n, w2_n, w3_n};
  end

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    rk_idx_d    = rk_idx_q;
    rk_valid_d  = rk_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          round_key_d = bus.cipher_key;
          rk_idx_d    = '0;
          rk_valid_d  = 1'b1;
          busy_d      = 1'b1;
          state_d     = GEN;
        end
      end
      GEN: begin
        if (xfer) begin
          if (rk_idx_q == LAST_IDX) begin
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            round_key_d = next_key;
            rk_idx_d    = rk_idx_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      rk_idx_q    <= '0;
      rk_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      rk_idx_q    <= rk_idx_d;
      rk_valid_q  <= rk_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.rk_valid  = rk_valid_q;
  assign bus.round_key = round_key_q;
  assign bus.rk_idx    = rk_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_key_expansion_128.sv
// Bench for key_expansion_128: reference schedule built from GF(2^8) arithmetic
// and the FIPS-197 word recursion, compared against every transferred key.
module tb_key_expansion_128;
  import aes_pkg::*;

  logic clk;
  logic rst_n;

  key_expansion_128_if bus ();

  key_expansion_128 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [AES_N-1:0] exp_keys [AES_R+1];
  logic [7:0]       sbox_tbl [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, miscompares=%0d", miscompares);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_tbl[a] = s;
    end
  endtask

  task automatic model_expand(input logic [AES_N-1:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_tbl[tmp[23:16]], sbox_tbl[tmp[15:8]], sbox_tbl[tmp[7:0]], sbox_tbl[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n          = 1'b1;
    bus.start      = 1'b0;
    bus.cipher_key = '0;
    bus.rk_ready   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.rk_valid, bus.busy, bus.done} !== 3'b000 || bus.round_key !== '0 || bus.rk_idx !== '0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b idx=%0d key=%h, expected all zero",
               bus.rk_valid, bus.busy, bus.done, bus.rk_idx, bus.round_key);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    vectors++;
    if ({bus.rk_valid, bus.busy, bus.done} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_after_reset: valid=%b busy=%b done=%b, expected 000",
               bus.rk_valid, bus.busy, bus.done);
    end
  endtask

  // FIPS-197 A.1 key and the all-zero key, with published round keys 1 and 10.
  task automatic test_known_vectors();
    logic [127:0] kv_key [2];
    logic [127:0] kv_rk1 [2];
    logic [127:0] kv_rk10 [2];
    kv_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    kv_rk1[0]  = 128'ha0fafe1788542cb123a339392a6c7605;
    kv_rk10[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    kv_key[1]  = 128'h0;
    kv_rk1[1]  = 128'h62636363626363636263636362636363;
    kv_rk10[1] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    for (int v = 0; v < 2; v++) begin
      model_expand(kv_key[v]);
      bus.cipher_key = kv_key[v];
      bus.start      = 1'b1;
      bus.rk_ready   = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 0; k <= 10; k++) begin
        vectors++;
        if (bus.rk_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
            bus.rk_idx !== IDX_W'(k) || bus.round_key !== exp_keys[k]) begin
          miscompares++;
          $display("FAIL kv_seq v=%0d k=%0d: valid=%b busy=%b done=%b idx=%0d key=%h, expected 1 1 0 %0d %h",
                   v, k, bus.rk_valid, bus.busy, bus.done, bus.rk_idx, bus.round_key, k, exp_keys[k]);
        end
        if (k == 0 || k == 1 || k == 10) begin
          vectors++;
          if (bus.round_key !== (k == 0 ? kv_key[v] : (k == 1 ? kv_rk1[v] : kv_rk10[v]))) begin
            miscompares++;
            $display("FAIL kv_published v=%0d k=%0d: key=%h, expected %h", v, k, bus.round_key,
                     (k == 0 ? kv_key[v] : (k == 1 ? kv_rk1[v] : kv_rk10[v])));
          end
        end
        step();
      end
      vectors++;
      if ({bus.done, bus.busy, bus.rk_valid} !== 3'b100) begin
        miscompares++;
        $display("FAIL kv_done_t12 v=%0d: done=%b busy=%b valid=%b, expected 1 0 0",
                 v, bus.done, bus.busy, bus.rk_valid);
      end
      step();
      vectors++;
      if (bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL kv_done_width v=%0d: done=%b, expected 0", v, bus.done);
      end
    end
  endtask

  task automatic test_stall();
    int e;
    int stall;
    e     = 0;
    stall = 0;
    model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    bus.cipher_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    bus.start      = 1'b1;
    bus.rk_ready   = 1'b1;
    step();
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 60 && e <= 10; cyc++) begin
      vectors++;
      if (bus.rk_valid !== 1'b1 || bus.rk_idx !== IDX_W'(e) || bus.round_key !== exp_keys[e]) begin
        miscompares++;
        $display("FAIL stall_seq cyc=%0d: valid=%b idx=%0d key=%h, expected 1 %0d %h",
                 cyc, bus.rk_valid, bus.rk_idx, bus.round_key, e, exp_keys[e]);
      end
      bus.rk_ready = !(e == 4 && stall < 3);
      if (!bus.rk_ready) stall++;
      step();
      if (bus.rk_ready) e++;
    end
    vectors++;
    if (e != 11 || stall != 3 || bus.done !== 1'b1 || bus.rk_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_end: keys=%0d stalls=%0d done=%b valid=%b, expected 11 3 1 0",
               e, stall, bus.done, bus.rk_valid);
    end
    bus.rk_ready = 1'b1;
    step();
  endtask

  task automatic test_start_while_busy();
    logic [127:0] key;
    int e;
    key = rand_key();
    e   = 0;
    model_expand(key);
    bus.cipher_key = key;
    bus.start      = 1'b1;
    bus.rk_ready   = 1'b1;
    step();
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 40 && e <= 10; cyc++) begin
      vectors++;
      if (bus.rk_valid !== 1'b1 || bus.rk_idx !== IDX_W'(e) || bus.round_key !== exp_keys[e]) begin
        miscompares++;
        $display("FAIL busy_start_seq cyc=%0d: valid=%b idx=%0d key=%h, expected 1 %0d %h",
                 cyc, bus.rk_valid, bus.rk_idx, bus.round_key, e, exp_keys[e]);
      end
      bus.start      = (e == 5);
      bus.cipher_key = (e == 5) ? ~key : key;
      step();
      e++;
    end
    bus.start = 1'b0;
    vectors++;
    if (e != 11 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_end: keys=%0d done=%b busy=%b, expected 11 1 0", e, bus.done, bus.busy);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [127:0] key;
    key = rand_key();
    model_expand(key);
    bus.cipher_key = key;
    bus.start      = 1'b1;
    bus.rk_ready   = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    vectors++;
    if (bus.rk_idx !== IDX_W'(6) || bus.round_key !== exp_keys[6]) begin
      miscompares++;
      $display("FAIL rst_mid_pre: idx=%0d key=%h, expected 6 %h", bus.rk_idx, bus.round_key, exp_keys[6]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.rk_valid, bus.busy, bus.done} !== 3'b000 || bus.round_key !== '0 || bus.rk_idx !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_async: valid=%b busy=%b done=%b idx=%0d key=%h, expected all zero",
               bus.rk_valid, bus.busy, bus.done, bus.rk_idx, bus.round_key);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    vectors++;
    if ({bus.rk_valid, bus.busy, bus.done} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_mid_release: valid=%b busy=%b done=%b, expected 000",
               bus.rk_valid, bus.busy, bus.done);
    end
    key = rand_key();
    model_expand(key);
    bus.cipher_key = key;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      vectors++;
      if (bus.rk_valid !== 1'b1 || bus.rk_idx !== IDX_W'(k) || bus.round_key !== exp_keys[k]) begin
        miscompares++;
        $display("FAIL rst_mid_restart k=%0d: valid=%b idx=%0d key=%h, expected 1 %0d %h",
                 k, bus.rk_valid, bus.rk_idx, bus.round_key, k, exp_keys[k]);
      end
      step();
    end
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_done: done=%b, expected 1", bus.done);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [127:0] k1;
    logic [127:0] k2;
    logic [127:0] exp1 [AES_R+1];
    int dones;
    dones = 0;
    k1 = rand_key();
    k2 = rand_key();
    model_expand(k1);
    exp1 = exp_keys;
    model_expand(k2);
    bus.cipher_key = k1;
    bus.start      = 1'b1;
    bus.rk_ready   = 1'b1;
    step();
    bus.cipher_key = k2;
    for (int c = 1; c <= 25; c++) begin
      logic         exp_valid;
      logic         exp_done;
      logic [127:0] exp_key;
      int           exp_idx;
      exp_valid = (c <= 11) || (c >= 13 && c <= 23);
      exp_done  = (c == 12) || (c == 24);
      exp_idx   = (c <= 11) ? c - 1 : c - 13;
      exp_key   = '0;
      if (c <= 11) exp_key = exp1[c-1];
      else if (exp_valid) exp_key = exp_keys[c-13];
      if (bus.done === 1'b1) dones++;
      vectors++;
      if (bus.rk_valid !== exp_valid || bus.done !== exp_done ||
          (exp_valid && (bus.rk_idx !== IDX_W'(exp_idx) || bus.round_key !== exp_key))) begin
        miscompares++;
        $display("FAIL b2b c=%0d: valid=%b done=%b idx=%0d key=%h, expected %b %b %0d %h",
                 c, bus.rk_valid, bus.done, bus.rk_idx, bus.round_key, exp_valid, exp_done, exp_idx, exp_key);
      end
      if (c == 24) bus.start = 1'b0;
      step();
    end
    vectors++;
    if (dones != 2) begin
      miscompares++;
      $display("FAIL b2b_done_count: saw %0d done pulses, expected 2", dones);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      logic [127:0] key;
      int e;
      key = rand_key();
      e   = 0;
      model_expand(key);
      repeat ($urandom_range(0, 3)) step();
      bus.cipher_key = key;
      bus.start      = 1'b1;
      bus.rk_ready   = 1'($urandom_range(0, 1));
      step();
      bus.start = 1'b0;
      for (int cyc = 0; cyc < 100 && e <= 10; cyc++) begin
        vectors++;
        if (bus.rk_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
            bus.rk_idx !== IDX_W'(e) || bus.round_key !== exp_keys[e]) begin
          miscompares++;
          $display("FAIL rand n=%0d cyc=%0d: valid=%b busy=%b done=%b idx=%0d key=%h, expected 1 1 0 %0d %h",
                   n, cyc, bus.rk_valid, bus.busy, bus.done, bus.rk_idx, bus.round_key, e, exp_keys[e]);
        end
        bus.rk_ready   = ($urandom_range(0, 3) != 0);
        bus.start      = ($urandom_range(0, 7) == 0);
        bus.cipher_key = rand_key();
        step();
        if (bus.rk_ready) e++;
      end
      bus.start = 1'b0;
      vectors++;
      if (e != 11 || bus.done !== 1'b1 || bus.rk_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_end n=%0d: keys=%0d done=%b valid=%b busy=%b, expected 11 1 0 0",
                 n, e, bus.done, bus.rk_valid, bus.busy);
      end
      step();
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_known_vectors();
    test_stall();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_expansion_128.md
Name: key_expansion_128

Overview:
AES-128 key schedule generator. It sits upstream of the round datapath. It expands a 128-bit cipher key into round keys 0..10, one per cycle, streamed over a valid/ready handshake with the round index attached. The round datapath consumes one round key per round instead of reusing the raw cipher key.

Parameters:
N, 128, key/round-key bit width (only 128 supported)
R, 10, number of rounds; round keys 0..R are emitted

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request expansion of cipher_key; sampled only in IDLE
cipher_key  in  N  key, w0 = [127:96] .. w3 = [31:0]; sampled on the cycle start is accepted
rk_valid  out  1  round_key/rk_idx hold a valid round key
rk_ready  in  1  consumer accepts the current round key
round_key  out  N  current round key
rk_idx  out  $clog2(R+1)  index of round_key, 0..R
busy  out  1  expansion in progress (GEN state)
done  out  1  one-cycle pulse after round key R is transferred

Behaviour:
- Reset (async assert, sync release): state=IDLE; round_key=0, rk_idx=0, rk_valid=0, busy=0, done=0. Asserting reset mid-expansion clears everything immediately; no partial keys are emitted after release.
- All outputs are registered.
- FSM states: IDLE, GEN.
- IDLE, start=1 at edge T:
  - round_key<=cipher_key, rk_idx<=0, rk_valid<=1, busy<=1, go to GEN.
  - round key 0 is visible in cycle T+1.
- GEN: a transfer is the edge where rk_valid && rk_ready.
  - Transfer with rk_idx<R: round_key<=next_key(round_key, rcon[rk_idx+1]), rk_idx<=rk_idx+1, rk_valid stays 1.
  - Transfer with rk_idx==R: rk_valid<=0, busy<=0, done<=1 for exactly one cycle, go to IDLE.
  - No transfer: round_key, rk_idx and rk_valid hold (backpressure). rk_ready may toggle arbitrarily.
- next_key, with words w0..w3 of the current key:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}, where RotWord({a,b,c,d}) = {b,c,d,a}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - All arithmetic is XOR; no carries.
- rcon for indices 1..10: 01,02,04,08,10,20,40,80,1b,36. rcon is generated combinationally from rk_idx; no state beyond round_key.
- Throughput with rk_ready held high:
  - start at T; key 0 visible T+1, key k visible T+1+k, key 10 visible T+11.
  - done is high in cycle T+12; start is accepted again at the T+12 edge.
- start while busy: ignored, cipher_key is not resampled.
- start in the same cycle as the final transfer: ignored, because the FSM is still in GEN. The requester must hold start until it is accepted; acceptance is visible as busy rising.
- cipher_key changes after acceptance: no effect on the expansion in progress.
- rk_idx never exceeds R; no wrap-around.

Decomposition:
- Shared package aes_pkg holds:
  - the S-box function (reused by the round datapath's SubBytes);
  - the rcon lookup function (index 1..10);
  - the FSM state enum typedef;
  - constants AES_N=128, AES_R=10.
- One sub-module: aes_sub_word (32-bit in/out, four parallel S-box lookups, purely combinational), instantiated once on RotWord(w3).
- The top module holds the FSM, round_key and rk_idx registers, and the word XOR chain.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse, rk_ready=1 -> 11 consecutive valid cycles:
  - rk_idx 0 = key itself;
  - rk_idx 1 = a0fafe1788542cb123a339392a6c7605;
  - rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - done high exactly in cycle T+12.
- All-zero key, rk_ready=1 -> rk_idx 1 = 62636363626363636263636362636363; rk_idx 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- FIPS key, rk_ready low for 3 cycles while rk_idx=4 -> round_key and rk_idx stable through the stall; the sequence then resumes unchanged and key 10 still matches.
- start re-pulsed with a different cipher_key while busy, at rk_idx=5 -> ignored; the output sequence still matches the first key.
- rst_n asserted at rk_idx=6 -> rk_valid, busy, done, round_key and rk_idx are 0 immediately. After release, a new start produces a clean sequence from rk_idx 0.
- start held high continuously -> two back-to-back full expansions; the second key 0 is visible in cycle T+13, and done pulses once per expansion.
